// File: rtl/truth_table_scanner_pkg.sv
// Shared types and helpers for the truth-table scanner.
package truth_table_scanner_pkg;

  // Scanner control states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } scan_state_e;

  // Default block size: 4 inputs, 16 vectors.
  localparam int DEF_N_IN = 4;
  localparam int NUM_VEC  = 2 ** DEF_N_IN;

  // Width of a counter able to hold 0..settle_cyc (at least one bit).
  function automatic int settle_cnt_w(input int settle_cyc);
    if (settle_cyc < 1) return 1;
    return $clog2(settle_cyc + 1);
  endfunction

endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// Loadable down-counter that holds each vector for SETTLE_CYC extra cycles.
// zero is high when the counter has expired; with SETTLE_CYC = 0 the load
// value is 0, so zero never drops.
module scan_settle_timer
  import truth_table_scanner_pkg::*;
#(
  parameter int SETTLE_CYC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CNT_W = settle_cnt_w(SETTLE_CYC);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load has priority, decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(SETTLE_CYC);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Walks all 2^N_IN input vectors through a combinational candidate, captures
// its truth table and counts mismatches against a latched target table.
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int N_IN       = DEF_N_IN,
  parameter int SETTLE_CYC = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [(2**N_IN)-1:0]   target,
  output logic [N_IN-1:0]        vec_out,
  input  logic                   dut_out,
  output logic                   busy,
  output logic                   done,
  output logic [(2**N_IN)-1:0]   truth_tbl,
  output logic [N_IN:0]          mismatch_cnt,
  output logic                   perfect,
  output logic [1:0]             dbg_state
);

  localparam int TBL_W = 2 ** N_IN;
  localparam logic [N_IN-1:0] VEC_LAST = N_IN'(TBL_W - 1);

  scan_state_e       state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [TBL_W-1:0]  tgt_q, tgt_d;
  logic [TBL_W-1:0]  tbl_q, tbl_d;
  logic [N_IN:0]     cnt_q, cnt_d;
  logic              perfect_q, perfect_d;
  logic              tmr_load, tmr_dec, tmr_zero;
  logic              miss;

  scan_settle_timer #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .dec   (tmr_dec),
    .zero  (tmr_zero)
  );

  // Next-state, vector stepping, table capture and mismatch accumulation.
  // Abort wins over a sample that would land on the same edge.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    tgt_d     = tgt_q;
    tbl_d     = tbl_q;
    cnt_d     = cnt_q;
    perfect_d = perfect_q;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    miss      = dut_out ^ tgt_q[vec_q];
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SETTLE;
          vec_d     = '0;
          tgt_d     = target;
          tbl_d     = '0;
          cnt_d     = '0;
          perfect_d = 1'b0;
          tmr_load  = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d   = ST_IDLE;
          vec_d     = '0;
          tbl_d     = '0;
          cnt_d     = '0;
          perfect_d = 1'b0;
        end else if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else begin
          tbl_d[vec_q] = dut_out;
          cnt_d        = cnt_q + (N_IN+1)'(miss);
          if (vec_q != VEC_LAST) begin
            vec_d    = vec_q + N_IN'(1);
            tmr_load = 1'b1;
          end else begin
            state_d   = ST_DONE;
            vec_d     = '0;
            perfect_d = (cnt_d == '0);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      vec_q     <= '0;
      tgt_q     <= '0;
      tbl_q     <= '0;
      cnt_q     <= '0;
      perfect_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      tgt_q     <= tgt_d;
      tbl_q     <= tbl_d;
      cnt_q     <= cnt_d;
      perfect_q <= perfect_d;
    end
  end

  assign vec_out      = vec_q;
  assign busy         = (state_q == ST_SETTLE);
  assign done         = (state_q == ST_DONE);
  assign truth_tbl    = tbl_q;
  assign mismatch_cnt = cnt_q;
  assign perfect      = perfect_q;
  assign dbg_state    = state_q;

endmodule
